// File: rtl/mem_access_pkg.sv
// Shared uDLX opcode constants and the memory-access stage state encoding.
package mem_access_pkg;

    localparam logic [5:0] R_TYPE_OPCODE = 6'h00;
    localparam logic [5:0] LW_OPCODE     = 6'h23;
    localparam logic [5:0] SW_OPCODE     = 6'h2B;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a bus ack and flags the
// cycle in which the wait-state limit is reached.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run_in,
    output logic expire_out
);

    localparam int unsigned CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] count_q, count_d;

    // Count while waiting, clear as soon as the wait ends.
    always_comb begin
        count_d = run_in ? count_q + 1'b1 : '0;
    end

    assign expire_out = run_in && (count_q == CW'(LIMIT - 1));

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: uDLX memory-access stage. Runs one req/ack data-memory
// transaction per LW/SW, stalls upstream meanwhile, and issues a registered
// write-back bundle. Optional wait-state timeout: `define MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned OPCODE_WIDTH       = 6,
    parameter int unsigned REG_ADDR_WIDTH     = 5,
    parameter int unsigned MEM_TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid_in,
    input  logic [OPCODE_WIDTH-1:0]   ex_opcode_in,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result_in,
    input  logic [DATA_WIDTH-1:0]     ex_store_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dest_reg_in,
    input  logic                      ex_reg_we_in,
    output logic                      stall_out,
    output logic                      mem_req_out,
    output logic                      mem_we_out,
    output logic [ADDR_WIDTH-1:0]     mem_addr_out,
    output logic [DATA_WIDTH-1:0]     mem_wdata_out,
    input  logic                      mem_ack_in,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_in,
    output logic                      wb_valid_out,
    output logic [DATA_WIDTH-1:0]     wb_data_out,
    output logic [REG_ADDR_WIDTH-1:0] wb_dest_reg_out,
    output logic                      wb_reg_we_out,
    output logic                      mem_error_out
);

    mem_state_e                state_q, state_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_WIDTH-1:0] pend_dest_q, pend_dest_d;
    logic                      pend_we_q, pend_we_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
    logic                      wb_we_q, wb_we_d;
    logic                      err_q, err_d;

    logic                      timeout;
    logic                      is_lw, is_sw;
    logic [ADDR_WIDTH-1:0]     addr_in;

    assign is_lw   = (ex_opcode_in == OPCODE_WIDTH'(LW_OPCODE));
    assign is_sw   = (ex_opcode_in == OPCODE_WIDTH'(SW_OPCODE));
    assign addr_in = ADDR_WIDTH'(ex_alu_result_in);

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .run_in     (state_q == ST_WAIT),
        .expire_out (timeout)
    );
`else
    // No timer: the limit is inert and the stage waits for ack indefinitely.
    assign timeout = (MEM_TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/WAIT controller.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pend_dest_d = pend_dest_q;
        pend_we_d   = pend_we_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_dest_d   = wb_dest_q;
        wb_we_d     = wb_we_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_in) begin
                    if (is_lw || is_sw) begin
                        if (addr_in[1:0] == 2'b00) begin
                            state_d     = ST_WAIT;
                            req_d       = 1'b1;
                            we_d        = is_sw;
                            addr_d      = addr_in;
                            wdata_d     = ex_store_data_in;
                            pend_dest_d = ex_dest_reg_in;
                            pend_we_d   = ex_reg_we_in;
                        end else begin
                            wb_valid_d = 1'b1;
                            wb_data_d  = ex_alu_result_in;
                            wb_dest_d  = ex_dest_reg_in;
                            wb_we_d    = 1'b0;
                            err_d      = 1'b1;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result_in;
                        wb_dest_d  = ex_dest_reg_in;
                        wb_we_d    = ex_reg_we_in;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ack_in) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = we_q ? '0 : mem_rdata_in;
                    wb_dest_d  = pend_dest_q;
                    wb_we_d    = !we_q && pend_we_q;
                end else if (timeout) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_dest_d  = pend_dest_q;
                    wb_we_d    = 1'b0;
                    err_d      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears everything and drops req at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pend_dest_q <= '0;
            pend_we_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dest_q   <= '0;
            wb_we_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pend_dest_q <= pend_dest_d;
            pend_we_q   <= pend_we_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dest_q   <= wb_dest_d;
            wb_we_q     <= wb_we_d;
            err_q       <= err_d;
        end
    end

    assign stall_out       = (state_q != ST_IDLE);
    assign mem_req_out     = req_q;
    assign mem_we_out      = we_q;
    assign mem_addr_out    = addr_q;
    assign mem_wdata_out   = wdata_q;
    assign wb_valid_out    = wb_valid_q;
    assign wb_data_out     = wb_data_q;
    assign wb_dest_reg_out = wb_dest_q;
    assign wb_reg_we_out   = wb_we_q;
    assign mem_error_out   = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid_in = 1'b0;
    logic [5:0]  ex_opcode_in = '0;
    logic [31:0] ex_alu_result_in = '0;
    logic [31:0] ex_store_data_in = '0;
    logic [4:0]  ex_dest_reg_in = '0;
    logic        ex_reg_we_in = 1'b0;
    logic        stall_out, mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic        mem_ack_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        wb_valid_out;
    logic [31:0] wb_data_out;
    logic [4:0]  wb_dest_reg_out;
    logic        wb_reg_we_out, mem_error_out;

    int total = 0;
    int bad = 0;

    mem_access #(
        .DATA_WIDTH         (32),
        .ADDR_WIDTH         (32),
        .OPCODE_WIDTH       (6),
        .REG_ADDR_WIDTH     (5),
        .MEM_TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_in      (ex_valid_in),
        .ex_opcode_in     (ex_opcode_in),
        .ex_alu_result_in (ex_alu_result_in),
        .ex_store_data_in (ex_store_data_in),
        .ex_dest_reg_in   (ex_dest_reg_in),
        .ex_reg_we_in     (ex_reg_we_in),
        .stall_out        (stall_out),
        .mem_req_out      (mem_req_out),
        .mem_we_out       (mem_we_out),
        .mem_addr_out     (mem_addr_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_ack_in       (mem_ack_in),
        .mem_rdata_in     (mem_rdata_in),
        .wb_valid_out     (wb_valid_out),
        .wb_data_out      (wb_data_out),
        .wb_dest_reg_out  (wb_dest_reg_out),
        .wb_reg_we_out    (wb_reg_we_out),
        .mem_error_out    (mem_error_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] dest, input logic we);
        ex_valid_in      = 1'b1;
        ex_opcode_in     = op;
        ex_alu_result_in = alu;
        ex_store_data_in = sd;
        ex_dest_reg_in   = dest;
        ex_reg_we_in     = we;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        total++; if ({stall_out, mem_req_out, mem_we_out, wb_valid_out, wb_reg_we_out, mem_error_out} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl got=%b exp=000000", {stall_out, mem_req_out, mem_we_out, wb_valid_out, wb_reg_we_out, mem_error_out}); end
        total++; if ({mem_addr_out, mem_wdata_out, wb_data_out, wb_dest_reg_out} !== 101'b0) begin
            bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr_out, mem_wdata_out, wb_data_out, wb_dest_reg_out); end
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_pass_through();
        drive(R_TYPE_OPCODE, 32'h0000_0042, 32'h0, 5'd3, 1'b1);
        step();
        ex_valid_in = 1'b0;
        total++; if (wb_valid_out !== 1'b1) begin bad++; $display("FAIL pt_valid got=%b exp=1", wb_valid_out); end
        total++; if (wb_data_out !== 32'h42) begin bad++; $display("FAIL pt_data got=%h exp=42", wb_data_out); end
        total++; if (wb_dest_reg_out !== 5'd3) begin bad++; $display("FAIL pt_dest got=%0d exp=3", wb_dest_reg_out); end
        total++; if (wb_reg_we_out !== 1'b1) begin bad++; $display("FAIL pt_we got=%b exp=1", wb_reg_we_out); end
        total++; if (stall_out !== 1'b0 || mem_req_out !== 1'b0) begin
            bad++; $display("FAIL pt_stall got=%b%b exp=00", stall_out, mem_req_out); end
        step();
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL pt_pulse got=%b exp=0", wb_valid_out); end
    endtask

    task automatic test_load();
        drive(LW_OPCODE, 32'h0000_0100, 32'h0, 5'd5, 1'b1);
        step();
        ex_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if ({mem_req_out, mem_we_out, stall_out, wb_valid_out} !== 4'b1010) begin
                bad++; $display("FAIL lw_wait%0d req/we/stall/wbv got=%b exp=1010", i, {mem_req_out, mem_we_out, stall_out, wb_valid_out}); end
            total++; if (mem_addr_out !== 32'h100) begin bad++; $display("FAIL lw_addr%0d got=%h exp=100", i, mem_addr_out); end
            if (i == 2) begin
                mem_ack_in   = 1'b1;
                mem_rdata_in = 32'hDEAD_BEEF;
            end
            step();
        end
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        total++; if (wb_valid_out !== 1'b1 || wb_data_out !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL lw_wb got=%b %h exp=1 deadbeef", wb_valid_out, wb_data_out); end
        total++; if (wb_reg_we_out !== 1'b1 || wb_dest_reg_out !== 5'd5) begin
            bad++; $display("FAIL lw_wb_we got=%b %0d exp=1 5", wb_reg_we_out, wb_dest_reg_out); end
        total++; if (mem_req_out !== 1'b0 || stall_out !== 1'b0) begin
            bad++; $display("FAIL lw_done got=%b%b exp=00", mem_req_out, stall_out); end
        step();
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL lw_pulse got=%b exp=0", wb_valid_out); end
    endtask

    task automatic test_back_to_back();
        drive(SW_OPCODE, 32'h0000_0020, 32'h0000_1234, 5'd7, 1'b0);
        step();
        drive(R_TYPE_OPCODE, 32'h0000_0077, 32'h0, 5'd9, 1'b1);
        total++; if ({mem_req_out, mem_we_out, stall_out} !== 3'b111) begin
            bad++; $display("FAIL sw_req got=%b exp=111", {mem_req_out, mem_we_out, stall_out}); end
        total++; if (mem_wdata_out !== 32'h1234 || mem_addr_out !== 32'h20) begin
            bad++; $display("FAIL sw_bus got=%h %h exp=1234 20", mem_wdata_out, mem_addr_out); end
        mem_ack_in = 1'b1;
        step();
        mem_ack_in = 1'b0;
        total++; if (wb_valid_out !== 1'b1 || wb_reg_we_out !== 1'b0 || stall_out !== 1'b0) begin
            bad++; $display("FAIL sw_wb got=%b%b%b exp=100", wb_valid_out, wb_reg_we_out, stall_out); end
        step();
        ex_valid_in = 1'b0;
        total++; if (wb_valid_out !== 1'b1 || wb_data_out !== 32'h77 || wb_dest_reg_out !== 5'd9) begin
            bad++; $display("FAIL b2b_next got=%b %h %0d exp=1 77 9", wb_valid_out, wb_data_out, wb_dest_reg_out); end
        step();
    endtask

    task automatic test_misaligned();
        drive(LW_OPCODE, 32'h0000_0102, 32'h0, 5'd4, 1'b1);
        step();
        ex_valid_in = 1'b0;
        total++; if ({mem_req_out, mem_error_out, wb_valid_out, wb_reg_we_out, stall_out} !== 5'b01100) begin
            bad++; $display("FAIL mis got req/err/wbv/we/stall=%b exp=01100", {mem_req_out, mem_error_out, wb_valid_out, wb_reg_we_out, stall_out}); end
        step();
        total++; if (mem_error_out !== 1'b0 || wb_valid_out !== 1'b0) begin
            bad++; $display("FAIL mis_pulse got=%b%b exp=00", mem_error_out, wb_valid_out); end
    endtask

    task automatic test_idle();
        mem_ack_in = 1'b1;
        mem_rdata_in = 32'h5555_5555;
        step();
        step();
        mem_ack_in = 1'b0;
        total++; if (wb_valid_out !== 1'b0 || mem_req_out !== 1'b0 || stall_out !== 1'b0) begin
            bad++; $display("FAIL idle got=%b%b%b exp=000", wb_valid_out, mem_req_out, stall_out); end
    endtask

    task automatic test_reset_mid();
        drive(LW_OPCODE, 32'h0000_0040, 32'h0, 5'd6, 1'b1);
        step();
        ex_valid_in = 1'b0;
        total++; if (mem_req_out !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", mem_req_out); end
        #2 rst = 1'b0;
        #1;
        total++; if (mem_req_out !== 1'b0 || stall_out !== 1'b0) begin
            bad++; $display("FAIL rm_async got=%b%b exp=00", mem_req_out, stall_out); end
        #2 rst = 1'b1;
        mem_ack_in = 1'b1;
        step();
        mem_ack_in = 1'b0;
        total++; if (wb_valid_out !== 1'b0) begin bad++; $display("FAIL rm_nowb got=%b exp=0", wb_valid_out); end
        drive(R_TYPE_OPCODE, 32'h0000_00A5, 32'h0, 5'd11, 1'b1);
        step();
        ex_valid_in = 1'b0;
        total++; if (wb_valid_out !== 1'b1 || wb_data_out !== 32'hA5 || wb_dest_reg_out !== 5'd11 || wb_reg_we_out !== 1'b1) begin
            bad++; $display("FAIL rm_add got=%b %h %0d %b exp=1 a5 11 1", wb_valid_out, wb_data_out, wb_dest_reg_out, wb_reg_we_out); end
        step();
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        drive(LW_OPCODE, 32'h0000_0080, 32'h0, 5'd8, 1'b1);
        step();
        ex_valid_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++; if (mem_req_out !== 1'b1 || mem_error_out !== 1'b0) begin
                bad++; $display("FAIL to_wait%0d got=%b%b exp=10", i, mem_req_out, mem_error_out); end
            step();
        end
        total++; if ({mem_req_out, mem_error_out, wb_valid_out, wb_reg_we_out, stall_out} !== 5'b01100) begin
            bad++; $display("FAIL to_expire req/err/wbv/we/stall got=%b exp=01100", {mem_req_out, mem_error_out, wb_valid_out, wb_reg_we_out, stall_out}); end
        mem_ack_in = 1'b1;
        step();
        mem_ack_in = 1'b0;
        total++; if (wb_valid_out !== 1'b0 || mem_error_out !== 1'b0 || mem_req_out !== 1'b0) begin
            bad++; $display("FAIL to_late_ack got=%b%b%b exp=000", wb_valid_out, mem_error_out, mem_req_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_load();
        test_back_to_back();
        test_misaligned();
        test_idle();
        test_reset_mid();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
